// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ playback (DAC) path: fetch FSM encoding and
// lane/index width derivation used by the unpacker and its lane mux.
package daq_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_CAPT = 2'd2
    } fetch_state_e;

    localparam int DW_DEFAULT     = 32;
    localparam int DAC_DW_DEFAULT = 8;

    // Number of DAC samples packed in one FIFO word.
    function automatic int lanes_f(input int dw, input int dac_dw);
        return dw / dac_dw;
    endfunction

    // Lane index width; a single-lane build still keeps a 1-bit index.
    function automatic int idx_width_f(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int LANES_DEFAULT = lanes_f(DW_DEFAULT, DAC_DW_DEFAULT);

endpackage

// File: rtl/wb_daq_dac_unpack_if.sv
// Bus bundle between the playback FIFO / DAC pacing side and the unpacker.
// master drives FIFO status, data and requests; slave is the unpacker.
interface wb_daq_dac_unpack_if #(
    parameter int dw     = 32,
    parameter int dac_dw = 8
);
    logic              enable;
    logic              sample_req;
    logic              fifo_empty;
    logic [dw-1:0]     fifo_data_in;
    logic              fifo_pop;
    logic [dac_dw-1:0] data_out;
    logic              data_valid;
    logic              underrun;

    modport master (
        output enable, sample_req, fifo_empty, fifo_data_in,
        input  fifo_pop, data_out, data_valid, underrun
    );

    modport slave (
        input  enable, sample_req, fifo_empty, fifo_data_in,
        output fifo_pop, data_out, data_valid, underrun
    );
endinterface

// File: rtl/daq_lane_mux.sv
// Combinational lane select: picks sample idx (LSB lane first) out of a packed word.
module daq_lane_mux
    import daq_pkg::*;
#(
    parameter int dw     = 32,
    parameter int dac_dw = 8,
    parameter int idx_w  = 2
) (
    input  logic [dw-1:0]     word,
    input  logic [idx_w-1:0]  idx,
    output logic [dac_dw-1:0] sample
);
    localparam int LANES = lanes_f(dw, dac_dw);

    logic [dac_dw-1:0] lane_s [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_s[g] = word[g*dac_dw +: dac_dw];
    end

    assign sample = lane_s[idx];
endmodule

// File: rtl/wb_daq_dac_unpack.sv
// Playback unpacker: fetches packed words from the FIFO (one pop in flight, one
// prefetch word) and hands out one DAC sample per sample_req, LSB lane first.
module wb_daq_dac_unpack
    import daq_pkg::*;
#(
    parameter int dw     = 32,
    parameter int dac_dw = 8
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    wb_daq_dac_unpack_if.slave    bus
);
    localparam int               LANES    = lanes_f(dw, dac_dw);
    localparam int               IDX_W    = idx_width_f(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    fetch_state_e      state_r;
    logic [dw-1:0]     cur_r;
    logic [dw-1:0]     nxt_r;
    logic              cur_v_r;
    logic              nxt_v_r;
    logic [IDX_W-1:0]  idx_r;
    logic              fifo_pop_r;
    logic [dac_dw-1:0] data_out_r;
    logic              data_valid_r;
    logic              underrun_r;
    logic              enable_d_r;

    logic [dac_dw-1:0] lane_sample_s;
    logic              serve_s;
    logic              consume_last_s;
    logic              capture_s;
    logic              cur_v_next_s;
    logic              nxt_v_next_s;
    logic              fetch_ok_s;

    daq_lane_mux #(
        .dw     (dw),
        .dac_dw (dac_dw),
        .idx_w  (IDX_W)
    ) u_lane_mux (
        .word   (cur_r),
        .idx    (idx_r),
        .sample (lane_sample_s)
    );

    // Serve/capture decode and post-edge occupancy; a new fetch only starts if a slot is free after this edge.
    always_comb begin
        serve_s        = bus.enable & bus.sample_req & cur_v_r;
        consume_last_s = serve_s & (idx_r == LAST_IDX);
        capture_s      = bus.enable & (state_r == FETCH_CAPT);
        cur_v_next_s   = cur_v_r;
        nxt_v_next_s   = nxt_v_r;
        if (consume_last_s) begin
            cur_v_next_s = nxt_v_r | capture_s;
            nxt_v_next_s = nxt_v_r & capture_s;
        end else if (capture_s) begin
            if (cur_v_r) begin
                nxt_v_next_s = 1'b1;
            end else begin
                cur_v_next_s = 1'b1;
            end
        end else begin
            cur_v_next_s = cur_v_r;
            nxt_v_next_s = nxt_v_r;
        end
        fetch_ok_s = bus.enable & ~bus.fifo_empty & ~(cur_v_next_s & nxt_v_next_s);
    end

    // Fetch FSM with registered FIFO pop strobe.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_r    <= FETCH_IDLE;
            fifo_pop_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH_IDLE, FETCH_CAPT: begin
                    if (fetch_ok_s) begin
                        state_r    <= FETCH_REQ;
                        fifo_pop_r <= 1'b1;
                    end else begin
                        state_r    <= FETCH_IDLE;
                        fifo_pop_r <= 1'b0;
                    end
                end
                FETCH_REQ: begin
                    // The pop has already gone out; if disabled its data is simply never captured.
                    state_r    <= bus.enable ? FETCH_CAPT : FETCH_IDLE;
                    fifo_pop_r <= 1'b0;
                end
                default: begin
                    state_r    <= FETCH_IDLE;
                    fifo_pop_r <= 1'b0;
                end
            endcase
        end
    end

    // Word registers and lane index; a last-lane consume and a capture in one cycle both land.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            cur_r   <= '0;
            nxt_r   <= '0;
            cur_v_r <= 1'b0;
            nxt_v_r <= 1'b0;
            idx_r   <= '0;
        end else if (!bus.enable) begin
            cur_v_r <= 1'b0;
            nxt_v_r <= 1'b0;
            idx_r   <= '0;
        end else begin
            cur_v_r <= cur_v_next_s;
            nxt_v_r <= nxt_v_next_s;
            if (consume_last_s) begin
                idx_r <= '0;
                cur_r <= nxt_v_r ? nxt_r : bus.fifo_data_in;
                nxt_r <= bus.fifo_data_in;
            end else begin
                if (serve_s) begin
                    idx_r <= idx_r + IDX_W'(1);
                end
                if (capture_s) begin
                    if (cur_v_r) begin
                        nxt_r <= bus.fifo_data_in;
                    end else begin
                        cur_r <= bus.fifo_data_in;
                    end
                end
            end
        end
    end

    // Sample output, valid pulse and sticky underrun (cleared on enable falling).
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            underrun_r   <= 1'b0;
            enable_d_r   <= 1'b0;
        end else begin
            enable_d_r   <= bus.enable;
            data_valid_r <= serve_s;
            if (serve_s) begin
                data_out_r <= lane_sample_s;
            end
            if (enable_d_r & ~bus.enable) begin
                underrun_r <= 1'b0;
            end else if (bus.enable & bus.sample_req & ~cur_v_r) begin
                underrun_r <= 1'b1;
            end
        end
    end

    assign bus.fifo_pop   = fifo_pop_r;
    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.underrun   = underrun_r;
endmodule

// File: tb/tb_wb_daq_dac_unpack.sv
// Directed bench for wb_daq_dac_unpack: per-cycle vector table for the single
// word / underrun sequence plus hand-written multi-cycle sequences.
module tb_wb_daq_dac_unpack;

    typedef struct {
        logic       en;
        logic       req;
        logic       exp_pop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_und;
    } vec_t;

    logic wb_clk = 1'b0;
    logic wb_rst;

    always #5 wb_clk = ~wb_clk;

    wb_daq_dac_unpack_if #(.dw(32), .dac_dw(8)) bus ();

    wb_daq_dac_unpack #(.dw(32), .dac_dw(8)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (bus)
    );

    // Playback FIFO model: data appears the cycle after a pop.
    logic [31:0] fifo_mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          empty_pops = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge wb_clk) begin
        if (bus.fifo_pop) begin
            if (rd_ptr != wr_ptr) begin
                bus.fifo_data_in <= fifo_mem[rd_ptr % 64];
                rd_ptr           <= rd_ptr + 1;
            end else begin
                empty_pops <= empty_pops + 1;
            end
        end
    end

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs [18];

    function automatic vec_t mk(input logic en, input logic req, input logic pop,
                                input logic vld, input logic [7:0] d, input logic und);
        vec_t v;
        v.en = en; v.req = req; v.exp_pop = pop; v.exp_valid = vld; v.exp_data = d; v.exp_und = und;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic step(input logic en, input logic req);
        @(posedge wb_clk);
        #1;
        bus.enable     = en;
        bus.sample_req = req;
    endtask

    function automatic logic [31:0] outs();
        return {21'd0, bus.fifo_pop, bus.data_valid, bus.data_out, bus.underrun};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;

        // en, req -> pop, valid, data, underrun seen in that same cycle
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        vecs[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 1'b1);
        vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 1'b1);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0);

        wb_rst         = 1'b1;
        bus.enable     = 1'b0;
        bus.sample_req = 1'b0;
        @(negedge wb_clk);
        check("reset_state", outs(), 32'd0);
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;

        // Enabled with an empty FIFO: never pop.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            @(negedge wb_clk);
            check($sformatf("empty_no_pop[%0d]", i), {31'd0, bus.fifo_pop}, 32'd0);
        end
        check("empty_rd_ptr", rd_ptr, 32'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Single word, spaced requests, then underrun and its clearing.
        push(32'h44332211);
        base = rd_ptr;
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].en, vecs[i].req);
            @(negedge wb_clk);
            check($sformatf("vecA[%0d]", i), outs(),
                  {21'd0, vecs[i].exp_pop, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_und});
        end
        check("vecA_pops", rd_ptr - base, 32'd1);

        // Three words, back-to-back requests after startup.
        push(32'h04030201);
        push(32'h08070605);
        push(32'h0C0B0A09);
        base = rd_ptr;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i <= 12; i++) begin
            step(1'b1, (i < 12) ? 1'b1 : 1'b0);
            @(negedge wb_clk);
            if (i == 0) begin
                check("stream_first_idle", {31'd0, bus.data_valid}, 32'd0);
            end else begin
                check($sformatf("stream[%0d]", i - 1),
                      {22'd0, bus.data_valid, bus.data_out, bus.underrun},
                      {22'd0, 1'b1, 8'(i), 1'b0});
            end
        end
        step(1'b1, 1'b0);
        @(negedge wb_clk);
        check("stream_after", {30'd0, bus.data_valid, bus.underrun}, 32'd0);
        check("stream_pops", rd_ptr - base, 32'd3);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Drop enable after two lanes; remaining lanes and the prefetched word are discarded.
        push(32'hA3A2A1A0);
        push(32'hB3B2B1B0);
        base = rd_ptr;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        @(negedge wb_clk);
        check("drop_lane0", {23'd0, bus.data_valid, bus.data_out}, {23'd0, 1'b1, 8'hA0});
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        @(negedge wb_clk);
        check("drop_lane1", {23'd0, bus.data_valid, bus.data_out}, {23'd0, 1'b1, 8'hA1});
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        @(negedge wb_clk);
        check("drop_hold", outs(), {21'd0, 1'b0, 1'b0, 8'hA1, 1'b0});
        check("drop_pops", rd_ptr - base, 32'd2);
        push(32'hC3C2C1C0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        @(negedge wb_clk);
        check("reen_lane0", {23'd0, bus.data_valid, bus.data_out}, {23'd0, 1'b1, 8'hC0});
        step(1'b1, 1'b0);
        @(negedge wb_clk);
        check("reen_lane1", {23'd0, bus.data_valid, bus.data_out}, {23'd0, 1'b1, 8'hC1});
        check("reen_pops", rd_ptr - base, 32'd3);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Reset while a pop is on the bus.
        push(32'hD3D2D1D0);
        base = rd_ptr;
        step(1'b1, 1'b0);
        @(posedge wb_clk);
        #1;
        check("rst_in_req_pop", {31'd0, bus.fifo_pop}, 32'd1);
        wb_rst     = 1'b1;
        bus.enable = 1'b0;
        #1;
        check("rst_mid_outputs", outs(), 32'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        wb_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            @(negedge wb_clk);
            check($sformatf("rst_no_pop[%0d]", i), {31'd0, bus.fifo_pop}, 32'd0);
        end
        check("rst_pops", rd_ptr - base, 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        @(negedge wb_clk);
        check("rst_then_lane0", {23'd0, bus.data_valid, bus.data_out}, {23'd0, 1'b1, 8'hD0});
        check("rst_then_pops", rd_ptr - base, 32'd1);
        step(1'b0, 1'b0);

        check("no_empty_pops", empty_pops, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
